ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_arbiter.sv | 110 +++++++++++
 tb/tb_ram_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter, its two requesters and the shared single-port RAM.
// slave = arbiter side, master = requesters plus RAM side.
interface ram_arbiter_if #(
    parameter int Width       = 8,
    parameter int AddressSize = 4
);
    logic                   req0;
    logic                   req1;
    logic                   we0;
    logic                   we1;
    logic [AddressSize-1:0] addr0;
    logic [AddressSize-1:0] addr1;
    logic [Width-1:0]       D0;
    logic [Width-1:0]       D1;
    logic                   ack0;
    logic                   ack1;
    logic [Width-1:0]       Q0;
    logic [Width-1:0]       Q1;
    logic                   busy;
    logic                   ram_we;
    logic [AddressSize-1:0] ram_addr;
    logic [Width-1:0]       ram_D;
    logic [Width-1:0]       ram_Q;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, D0, D1, ram_Q,
        output ack0, ack1, Q0, Q1, busy, ram_we, ram_addr, ram_D
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, D0, D1, ram_Q,
        input  ack0, ack1, Q0, Q1, busy, ram_we, ram_addr, ram_D
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a shared single-port RAM; each access takes IDLE -> SERVE -> ACK.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed priority to requester 0.
module ram_arbiter #(
    parameter int Width       = 8,
    parameter int AddressSize = 4
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a request; owner keeps the previous grant
    // SERVE | RAM access for owner, write strobe active this cycle
    // ACK   | one-cycle ack to owner, read data already in Q

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [Width-1:0] q0_q, q0_d;
    logic [Width-1:0] q1_q, q1_d;
    logic             winner;
    logic             owner_we;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    // Holds the requester favoured on the next tie, i.e. the inverse of the last grant.
    logic rr_ptr_q, rr_ptr_d;
    assign winner = (bus.req0 && bus.req1) ? rr_ptr_q : ~bus.req0;
`else
    assign winner = ~bus.req0;
`endif

    assign owner_we = owner_q ? bus.we1 : bus.we0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            q0_q     <= '0;
            q1_q     <= '0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            rr_ptr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        q0_d     = q0_q;
        q1_d     = q1_q;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d  = SERVE;
                    owner_d  = winner;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                    rr_ptr_d = ~winner;
`endif
                end
            end
            SERVE: begin
                state_d = ACK;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                if (!owner_we) begin
                    if (owner_q) q1_d = bus.ram_Q;
                    else         q0_d = bus.ram_Q;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        // rst gates the strobe directly so a reset landing in SERVE never commits a write.
        bus.ram_we   = (state_q == SERVE) && owner_we && !rst;
        bus.ram_addr = owner_q ? bus.addr1 : bus.addr0;
        bus.ram_D    = owner_q ? bus.D1 : bus.D0;
        bus.ack0     = ack0_q;
        bus.ack1     = ack1_q;
        bus.Q0       = q0_q;
        bus.Q1       = q1_q;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random requester traffic checked against a
// transaction-level model (grant edge, completion edge, memory image, expected read data).
module tb_ram_arbiter;
    localparam int W     = 8;
    localparam int A     = 4;
    localparam int DEPTH = 1 << A;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]   r_req;
    logic [1:0]   r_we;
    logic [A-1:0] r_addr [2];
    logic [W-1:0] r_d    [2];
    logic [1:0]   pending;

    ram_arbiter_if #(.Width(W), .AddressSize(A)) bus ();

    ram_arbiter #(.Width(W), .AddressSize(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req0  = r_req[0];
    assign bus.req1  = r_req[1];
    assign bus.we0   = r_we[0];
    assign bus.we1   = r_we[1];
    assign bus.addr0 = r_addr[0];
    assign bus.addr1 = r_addr[1];
    assign bus.D0    = r_d[0];
    assign bus.D1    = r_d[1];

    // Shared RAM: combinational read, write on the clock edge.
    logic [W-1:0] ram_mem [DEPTH];
    assign bus.ram_Q = ram_mem[bus.ram_addr];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_D;
    end

    // Reference model state
    int           checks   = 0;
    int           failures = 0;
    int           e_n      = -1;
    int           grant_edge = -100;
    int           last_granted = -1;
    logic         g_owner  = 1'b0;
    logic         g_we     = 1'b0;
    logic [A-1:0] g_addr   = '0;
    logic [W-1:0] g_d      = '0;
    logic [W-1:0] m_mem [DEPTH];
    logic [W-1:0] exp_q [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge as seen by the model: reset, completion of the access in flight, or a new grant.
    task automatic model_edge();
        logic [1:0] rq;
        e_n++;
        rq = r_req;
        if (rst) begin
            grant_edge   = -100;
            last_granted = -1;
            exp_q[0]     = '0;
            exp_q[1]     = '0;
        end else if (e_n == grant_edge + 1) begin
            if (g_we) m_mem[g_addr] = g_d;
            else      exp_q[g_owner] = m_mem[g_addr];
        end else if (e_n >= grant_edge + 3 && rq != 2'b00) begin
            if (rq == 2'b11) g_owner = RR ? (last_granted == 0) : 1'b0;
            else             g_owner = (rq == 2'b10);
            last_granted = g_owner ? 1 : 0;
            grant_edge   = e_n;
            g_we         = r_we[g_owner];
            g_addr       = r_addr[g_owner];
            g_d          = r_d[g_owner];
        end
    endtask

    task automatic compare();
        check_val("ack0",   32'(bus.ack0),   32'(e_n == grant_edge + 1 && !g_owner));
        check_val("ack1",   32'(bus.ack1),   32'(e_n == grant_edge + 1 && g_owner));
        check_val("busy",   32'(bus.busy),   32'(e_n == grant_edge || e_n == grant_edge + 1));
        check_val("ram_we", 32'(bus.ram_we), 32'(e_n == grant_edge && g_we && !rst));
        check_val("Q0",     32'(bus.Q0),     32'(exp_q[0]));
        check_val("Q1",     32'(bus.Q1),     32'(exp_q[1]));
        if (e_n == grant_edge) begin
            check_val("ram_addr", 32'(bus.ram_addr), 32'(g_addr));
            check_val("ram_D",    32'(bus.ram_D),    32'(g_d));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic do_access(input int who, input logic we, input logic [A-1:0] addr,
                             input logic [W-1:0] d);
        logic seen;
        seen         = 1'b0;
        r_req[who]   = 1'b1;
        r_we[who]    = we;
        r_addr[who]  = addr;
        r_d[who]     = d;
        for (int n = 0; n < 6 && !seen; n++) begin
            cycle();
            seen = (who == 0) ? bus.ack0 : bus.ack1;
        end
        r_req[who] = 1'b0;
        check_val("ack_seen", 32'(seen), 32'd1);
        cycle();
    endtask

    initial begin
        int n_ack0;
        int n_ack1;
        int n_activity;
        logic [W-1:0] old5;

        r_req   = '0;
        r_we    = '0;
        pending = '0;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0;
            r_d[i]    = '0;
            exp_q[i]  = '0;
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Write 0xA5 to address 3 from requester 0, then read it back through requester 1
        do_access(0, 1'b1, 4'd3, 8'hA5);
        check_val("ram3_written", 32'(ram_mem[3]), 32'h0000_00A5);
        check_val("q0_after_write", 32'(bus.Q0), 32'h0);
        do_access(1, 1'b0, 4'd3, 8'h00);
        check_val("q1_read", 32'(bus.Q1), 32'h0000_00A5);
        check_val("q0_untouched", 32'(bus.Q0), 32'h0);

        // Fill the RAM so every later read has a defined reference value
        for (int a = 0; a < DEPTH; a++) do_access(a % 2, 1'b1, A'(a), W'($urandom));

        // Both requesters held continuously for 12 edges: four accesses
        r_req = 2'b11;
        r_we  = 2'b00;
        r_addr[0] = 4'd7;
        r_addr[1] = 4'd9;
        n_ack0 = 0;
        n_ack1 = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            n_ack0 += int'(bus.ack0);
            n_ack1 += int'(bus.ack1);
        end
        r_req = 2'b00;
        check_val("held_ack0_count", 32'(n_ack0), RR ? 32'd2 : 32'd4);
        check_val("held_ack1_count", 32'(n_ack1), RR ? 32'd2 : 32'd0);
        cycle();

        // Random traffic; each requester keeps its request stable until acked
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (pending[i] && ((i == 0) ? bus.ack0 : bus.ack1)) pending[i] = 1'b0;
                if (!pending[i]) begin
                    r_req[i]  = ($urandom_range(0, 2) != 0);
                    r_we[i]   = 1'($urandom_range(0, 1));
                    r_addr[i] = A'($urandom_range(0, DEPTH - 1));
                    r_d[i]    = W'($urandom);
                    pending[i] = r_req[i];
                end
            end
            cycle();
        end
        r_req   = 2'b00;
        pending = 2'b00;
        for (int c = 0; c < 3; c++) cycle();

        // Ten quiet cycles
        n_activity = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_activity += int'(bus.busy) + int'(bus.ram_we) + int'(bus.ack0) + int'(bus.ack1);
        end
        check_val("idle_activity", 32'(n_activity), 32'd0);

        // Reset landing in SERVE of a write to address 5
        old5      = ram_mem[5];
        r_req[0]  = 1'b1;
        r_we[0]   = 1'b1;
        r_addr[0] = 4'd5;
        r_d[0]    = ~old5;
        cycle();
        check_val("serve_we_before_rst", 32'(bus.ram_we), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_gates_we", 32'(bus.ram_we), 32'd0);
        cycle();
        check_val("rst_no_write", 32'(ram_mem[5]), 32'(old5));
        rst      = 1'b0;
        r_req[0] = 1'b0;
        cycle();
        cycle();
        check_val("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
